timer_counter3: RTL and testbench

//   Three-channel programmable down-counter peripheral at 0xF000_0004. It sits

---
 rtl/timer_counter3.sv | 122 ++++++++++++
 tb/tb_timer_counter3.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter3.sv
// timer_counter3: three-channel programmable down-counter peripheral.
// Each channel has a count and reload register, a shared prescaled tick, and
// a per-channel enable/mode field in the control register. The modes are
// one-shot, periodic pulse and square wave. Register read-back is combinational.
module timer_counter3 #(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             counter_we,
  input  logic [1:0]       counter_sel,
  input  logic [WIDTH-1:0] counter_val,
  output logic [WIDTH-1:0] counter_out,
  output logic             counter0_out,
  output logic             counter1_out,
  output logic             counter2_out
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_SQUARE   = 2'b10;

  logic [PW-1:0]    pre_cnt;
  logic             tick;
  logic [8:0]       ctrl;
  logic [WIDTH-1:0] count  [3];
  logic [WIDTH-1:0] reload [3];
  logic [2:0]       out;
  // Marks an output that is high only because of a periodic terminal count,
  // so it is dropped on the following edge regardless of later mode changes.
  logic [2:0]       pulse;

  assign tick = (pre_cnt == PRE_LAST);

  // Free-running prescaler; wraps to 0 on the tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // Control register; only the nine channel bits are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
    end else if (counter_we && counter_sel == 2'b11) begin
      ctrl <= counter_val[8:0];
    end
  end

  // Channel state: bus writes take priority over counting, and a disabled
  // channel holds both its count and its output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        count[i]  <= '0;
        reload[i] <= '0;
      end
      out   <= '0;
      pulse <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (counter_we && counter_sel == 2'(i)) begin
          reload[i] <= counter_val;
          count[i]  <= counter_val;
          out[i]    <= 1'b0;
          pulse[i]  <= 1'b0;
        end else if (ctrl[3*i+2]) begin
          if (tick && count[i] == '0) begin
            case (ctrl[3*i +: 2])
              MODE_PERIODIC: begin
                out[i]   <= 1'b1;
                pulse[i] <= 1'b1;
                count[i] <= reload[i];
              end
              MODE_SQUARE: begin
                out[i]   <= ~out[i];
                pulse[i] <= 1'b0;
                count[i] <= reload[i];
              end
              default: begin
                out[i]   <= 1'b1;
                pulse[i] <= 1'b0;
              end
            endcase
          end else begin
            if (pulse[i]) begin
              out[i] <= 1'b0;
            end
            pulse[i] <= 1'b0;
            if (tick) begin
              count[i] <= count[i] - WIDTH'(1);
            end
          end
        end
      end
    end
  end

  // Register read-back multiplexer.
  always_comb begin
    counter_out = '0;
    case (counter_sel)
      2'b00:   counter_out = count[0];
      2'b01:   counter_out = count[1];
      2'b10:   counter_out = count[2];
      default: counter_out = WIDTH'(ctrl);
    endcase
  end

  assign counter0_out = out[0];
  assign counter1_out = out[1];
  assign counter2_out = out[2];

endmodule

// File: tb/tb_timer_counter3.sv
// tb_timer_counter3: directed and random stimulus for timer_counter3, run on
// two instances (prescale 1 and prescale 4) against a behavioural model.
module tb_timer_counter3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [1:0]  sel;
  logic [31:0] val;

  logic [31:0] co1, co4;
  logic        a0, a1, a2, b0, b1, b2;

  int n_cmp = 0;
  int n_err = 0;

  // Model state, index 0 = prescale 1 instance, index 1 = prescale 4 instance.
  int unsigned mcnt  [2][3];
  int unsigned mrld  [2][3];
  bit          mout  [2][3];
  bit          mpend [2][3];
  int unsigned mctrl [2];
  int unsigned mpre  [2];
  int unsigned psc   [2] = '{1, 4};

  always #5 clk = ~clk;

  timer_counter3 #(.WIDTH(32), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .counter_we(we), .counter_sel(sel),
    .counter_val(val), .counter_out(co1),
    .counter0_out(a0), .counter1_out(a1), .counter2_out(a2)
  );

  timer_counter3 #(.WIDTH(32), .PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .counter_we(we), .counter_sel(sel),
    .counter_val(val), .counter_out(co4),
    .counter0_out(b0), .counter1_out(b1), .counter2_out(b2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 3; c++) begin
        mcnt[m][c] = 0; mrld[m][c] = 0; mout[m][c] = 0; mpend[m][c] = 0;
      end
      mctrl[m] = 0;
      mpre[m]  = 0;
    end
  endtask

  // One rising edge of the model, using the inputs the DUT just sampled.
  task automatic model_edge(input int m);
    bit          tk;
    int unsigned md;
    bit          en;
    tk = (mpre[m] == psc[m] - 1);
    for (int c = 0; c < 3; c++) begin
      md = (mctrl[m] >> (3 * c)) & 3;
      if (md == 3) md = 0;
      en = ((mctrl[m] >> (3 * c + 2)) & 1) != 0;
      if (we && sel == 2'(c)) begin
        mcnt[m][c] = val; mrld[m][c] = val; mout[m][c] = 0; mpend[m][c] = 0;
      end else if (en) begin
        if (tk && mcnt[m][c] == 0) begin
          if (md == 1) begin
            mout[m][c] = 1; mpend[m][c] = 1; mcnt[m][c] = mrld[m][c];
          end else if (md == 2) begin
            mout[m][c] = !mout[m][c]; mpend[m][c] = 0; mcnt[m][c] = mrld[m][c];
          end else begin
            mout[m][c] = 1; mpend[m][c] = 0;
          end
        end else begin
          if (mpend[m][c]) mout[m][c] = 0;
          mpend[m][c] = 0;
          if (tk) mcnt[m][c] = mcnt[m][c] - 1;
        end
      end
    end
    if (we && sel == 2'b11) mctrl[m] = val & 32'h1FF;
    mpre[m] = tk ? 0 : mpre[m] + 1;
  endtask

  function automatic logic [31:0] exp_read(input int m, input logic [1:0] s);
    return (s == 2'b11) ? mctrl[m] : mcnt[m][s];
  endfunction

  task automatic compare_all(input string tag);
    chk({tag, "_co1"}, co1, exp_read(0, sel));
    chk({tag, "_co4"}, co4, exp_read(1, sel));
    chk({tag, "_p1o0"}, 32'(a0), 32'(mout[0][0]));
    chk({tag, "_p1o1"}, 32'(a1), 32'(mout[0][1]));
    chk({tag, "_p1o2"}, 32'(a2), 32'(mout[0][2]));
    chk({tag, "_p4o0"}, 32'(b0), 32'(mout[1][0]));
    chk({tag, "_p4o1"}, 32'(b1), 32'(mout[1][1]));
    chk({tag, "_p4o2"}, 32'(b2), 32'(mout[1][2]));
  endtask

  task automatic tick_cycle(input string tag);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all(tag);
  endtask

  task automatic wr(input logic [1:0] s, input logic [31:0] v, input string tag);
    we = 1'b1; sel = s; val = v;
    tick_cycle(tag);
    we = 1'b0;
  endtask

  // Asynchronous reset pulse away from the clock edge, checked before any edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk({tag, "_co1"}, co1, 32'h0);
      chk({tag, "_co4"}, co4, 32'h0);
    end
    chk({tag, "_outs"}, {29'h0, a2, a1, a0}, 32'h0);
    chk({tag, "_outs4"}, {29'h0, b2, b1, b0}, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    int cs [6];
    int os [6];
    rst_n = 1'b0; we = 1'b0; sel = 2'b00; val = '0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("por_co1", co1, 32'h0);
      chk("por_co4", co4, 32'h0);
    end
    chk("por_outs", {29'h0, a2, a1, a0, b2, b1, b0}, 32'h0);
    rst_n = 1'b1;
    sel = 2'b00;

    // Reset while ch0 is loaded with 5 and enabled.
    wr(2'b00, 32'd5, "t1w");
    wr(2'b11, 32'h004, "t1c");
    sel = 2'b00;
    #1;
    chk("t1_pre_rst", co1, 32'd5);
    async_reset("t1_rst");

    // One-shot on ch0.
    wr(2'b00, 32'd3, "t2w");
    wr(2'b11, 32'h004, "t2c");
    sel = 2'b00;
    #1;
    chk("t2_cnt", co1, 32'd3);
    for (int k = 1; k <= 3; k++) begin
      tick_cycle("t2");
      chk("t2_cnt", co1, 32'(3 - k));
      chk("t2_out_low", 32'(a0), 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      tick_cycle("t2h");
      chk("t2_out_high", 32'(a0), 32'h1);
      chk("t2_cnt_hold", co1, 32'h0);
    end

    // Periodic on ch1, reload 2.
    wr(2'b01, 32'd2, "t3w");
    wr(2'b11, 32'h028, "t3c");
    sel = 2'b01;
    cs = '{1, 0, 2, 1, 0, 2};
    os = '{0, 0, 1, 0, 0, 1};
    for (int k = 0; k < 6; k++) begin
      tick_cycle("t3");
      chk("t3_cnt", co1, 32'(cs[k]));
      chk("t3_pulse", 32'(a1), 32'(os[k]));
    end

    // Square wave on ch2, reload 1, then freeze and resume.
    wr(2'b10, 32'd1, "t4w");
    wr(2'b11, 32'h180, "t4c");
    sel = 2'b10;
    cs = '{0, 1, 0, 1, 0, 1};
    os = '{0, 1, 1, 0, 0, 1};
    for (int k = 0; k < 6; k++) begin
      tick_cycle("t4");
      chk("t4_cnt", co1, 32'(cs[k]));
      chk("t4_sq", 32'(a2), 32'(os[k]));
    end
    wr(2'b11, 32'h000, "t4dis");
    sel = 2'b10;
    repeat (4) tick_cycle("t4frz");
    wr(2'b11, 32'h180, "t4en");
    sel = 2'b10;
    repeat (5) tick_cycle("t4res");

    // Write collides with terminal count on periodic ch1.
    wr(2'b01, 32'd2, "t5w");
    wr(2'b11, 32'h028, "t5c");
    sel = 2'b01;
    tick_cycle("t5a");
    tick_cycle("t5b");
    chk("t5_at_zero", co1, 32'h0);
    wr(2'b01, 32'd7, "t5col");
    sel = 2'b01;
    #1;
    chk("t5_cnt", co1, 32'd7);
    chk("t5_nopulse", 32'(a1), 32'h0);
    tick_cycle("t5n");
    chk("t5_cnt_next", co1, 32'd6);
    chk("t5_out_next", 32'(a1), 32'h0);

    // Prescale 4 one-shot, with prescaler phase aligned by reset.
    async_reset("t6_rst");
    wr(2'b00, 32'd2, "t6w");
    wr(2'b11, 32'h004, "t6c");
    sel = 2'b00;
    for (int k = 0; k < 12; k++) tick_cycle("t6");
    chk("t6_p4_out", 32'(b0), 32'h1);
    chk("t6_p4_cnt", co4, 32'h0);

    // Random traffic including upper ctrl bits and reload values 0..5.
    for (int k = 0; k < 400; k++) begin
      we  = ($urandom_range(0, 3) == 0);
      sel = 2'($urandom_range(0, 3));
      val = (sel == 2'b11) ? $urandom : 32'($urandom_range(0, 5));
      tick_cycle("rnd");
    end
    we = 1'b0;
    async_reset("rnd_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
